// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the mux select sequencer: scan mode encoding,
// select width and the modulo-4 select increment.
package mux_sel_sequencer_pkg;

  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Natural overflow of the SEL_W-bit result gives the 3 -> 0 wrap.
  function automatic sel_t sel_next(input sel_t cur);
    return cur + sel_t'(1);
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Board-facing signal bundle of the select sequencer: raw active-low keys in,
// select code, scan mode and change strobe out.
interface mux_sel_sequencer_if;
  import mux_sel_sequencer_pkg::*;

  logic key_step_n;
  logic key_mode_n;
  sel_t sel;
  logic scan_mode;
  logic sel_change;

  // No valid/ready handshake: keys are free-running levels and sel_change is a
  // one-cycle strobe that is high exactly in the cycle sel holds a new value.
  modport master (
    output key_step_n,
    output key_mode_n,
    input  sel,
    input  scan_mode,
    input  sel_change
  );

  modport slave (
    input  key_step_n,
    input  key_mode_n,
    output sel,
    output scan_mode,
    output sel_change
  );

endinterface

// File: rtl/mux_sel_sequencer_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle pulse on the debounced press (1 -> 0) edge.
module key_debounce
  import mux_sel_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Released (1) is the reset level everywhere, so reset release with keys up
  // never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync_2;
        press <= ~sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Select generator for the 2-bit 4:1 mux: steps sel on a debounced button press
// in MANUAL mode, or auto-scans every SCAN_CYCLES in AUTO mode.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_CYCLES     = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_sel_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] SCAN_MAX = CNT_W'(SCAN_CYCLES - 1);

  logic             step_press;
  logic             mode_press;
  mode_e            mode;
  sel_t             sel;
  logic             sel_change;
  logic [CNT_W-1:0] scan_cnt;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_step_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_step_n),
    .press (step_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_mode_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_mode_n),
    .press (mode_press)
  );

  // A mode press wins over everything: a step in the same cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode       <= MODE_MANUAL;
      sel        <= '0;
      sel_change <= 1'b0;
      scan_cnt   <= '0;
    end else begin
      sel_change <= 1'b0;
      if (mode_press) begin
        mode     <= (mode == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
        scan_cnt <= '0;
      end else if (mode == MODE_MANUAL) begin
        scan_cnt <= '0;
        if (step_press) begin
          sel        <= sel_next(sel);
          sel_change <= 1'b1;
        end
      end else begin
        // Step and expiry together still advance by one and restart the period.
        if (step_press || (scan_cnt == SCAN_MAX)) begin
          sel        <= sel_next(sel);
          sel_change <= 1'b1;
          scan_cnt   <= '0;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.sel        = sel;
  assign bus.scan_mode  = mode;
  assign bus.sel_change = sel_change;

endmodule
